// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 engine scheduler.
// Owner encoding selects which agent drives the single S-memory port.
package arc4_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ENG_RST,
    S_INIT_EN,
    S_INIT_WAIT,
    S_KSA_EN,
    S_KSA_WAIT,
    S_PRGA_EN,
    S_PRGA_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA,
    OWN_PRGA,
    OWN_HOST
  } owner_t;

  localparam int ENG_INIT    = 0;
  localparam int ENG_KSA     = 1;
  localparam int ENG_PRGA    = 2;
  localparam int NUM_ENG     = 3;
  localparam int PHASE_CNT_W = 12;

  function automatic owner_t owner_of(state_t s);
    owner_t o;
    case (s)
      S_INIT_EN, S_INIT_WAIT: o = OWN_INIT;
      S_KSA_EN,  S_KSA_WAIT:  o = OWN_KSA;
      S_PRGA_EN, S_PRGA_WAIT: o = OWN_PRGA;
      S_IDLE, S_DONE, S_ERR:  o = OWN_HOST;
      default:                o = OWN_NONE;
    endcase
    return o;
  endfunction

  function automatic logic [NUM_ENG-1:0] en_bit(int idx);
    return NUM_ENG'(1) << idx;
  endfunction

endpackage

// File: rtl/arc4_sched_mem_mux.sv
// Combinational S-memory port mux: one engine slice, the host, or nobody.
// A start request in the same cycle blocks the host grant.
module s_mem_mux
  import arc4_pkg::*;
(
  input  owner_t      owner,
  input  logic [23:0] eng_addr,
  input  logic [23:0] eng_wrdata,
  input  logic [2:0]  eng_wren,
  input  logic        host_req,
  input  logic [7:0]  host_addr,
  input  logic        host_block,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wrdata,
  output logic        mem_wren,
  output logic        host_gnt
);

  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_wren   = 1'b0;
    host_gnt   = 1'b0;
    case (owner)
      OWN_INIT: begin
        mem_addr   = eng_addr[8*ENG_INIT +: 8];
        mem_wrdata = eng_wrdata[8*ENG_INIT +: 8];
        mem_wren   = eng_wren[ENG_INIT];
      end
      OWN_KSA: begin
        mem_addr   = eng_addr[8*ENG_KSA +: 8];
        mem_wrdata = eng_wrdata[8*ENG_KSA +: 8];
        mem_wren   = eng_wren[ENG_KSA];
      end
      OWN_PRGA: begin
        mem_addr   = eng_addr[8*ENG_PRGA +: 8];
        mem_wrdata = eng_wrdata[8*ENG_PRGA +: 8];
        mem_wren   = eng_wren[ENG_PRGA];
      end
      OWN_HOST: begin
        // host port is read-only
        mem_addr = host_addr;
        host_gnt = host_req & ~host_block;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// Sequences the INIT -> KSA -> PRGA engines with per-phase timeout and
// arbitrates the shared S-memory port between the active engine and the host.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] key,
  output logic [23:0] key_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        eng_rst_n,
  output logic [2:0]  eng_en,
  input  logic [2:0]  eng_rdy,
  input  logic [23:0] eng_addr,
  input  logic [23:0] eng_wrdata,
  input  logic [2:0]  eng_wren,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wrdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_rddata,
  input  logic        host_req,
  input  logic [7:0]  host_addr,
  output logic        host_gnt,
  output logic        host_valid,
  output logic [7:0]  host_rddata
);

  // state     | meaning
  // IDLE      | waiting for start, host may read memory
  // ENG_RST   | engines held in reset for two cycles
  // X_EN      | one-cycle enable pulse to engine X, counter cleared
  // X_WAIT    | waiting for engine X ready, counting toward timeout
  // DONE      | run completed, host may read memory
  // ERR       | phase timed out, engines held in reset

  localparam logic [PHASE_CNT_W-1:0] TO_LAST = PHASE_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic                   rst_cnt;
  logic [PHASE_CNT_W-1:0] phase_cnt;
  logic                   phase_timeout;

  assign phase_timeout = (phase_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      eng_en    <= '0;
      eng_rst_n <= 1'b0;
      key_out   <= '0;
      phase_cnt <= '0;
      rst_cnt   <= 1'b0;
    end else begin
      eng_en <= '0;
      if (state inside {S_INIT_WAIT, S_KSA_WAIT, S_PRGA_WAIT} && phase_cnt != '1)
        phase_cnt <= phase_cnt + 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_ENG_RST;
            key_out   <= key;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            eng_rst_n <= 1'b0;
            rst_cnt   <= 1'b0;
          end else if (state == S_IDLE) begin
            eng_rst_n <= 1'b1;
          end
        end
        S_ENG_RST: begin
          rst_cnt <= 1'b1;
          if (rst_cnt) begin
            state     <= S_INIT_EN;
            eng_rst_n <= 1'b1;
            eng_en    <= en_bit(ENG_INIT);
          end
        end
        S_INIT_EN: begin
          state     <= S_INIT_WAIT;
          phase_cnt <= '0;
        end
        S_INIT_WAIT: begin
          if (eng_rdy[ENG_INIT]) begin
            state  <= S_KSA_EN;
            eng_en <= en_bit(ENG_KSA);
          end else if (phase_timeout) begin
            state     <= S_ERR;
            busy      <= 1'b0;
            err       <= 1'b1;
            eng_rst_n <= 1'b0;
          end
        end
        S_KSA_EN: begin
          state     <= S_KSA_WAIT;
          phase_cnt <= '0;
        end
        S_KSA_WAIT: begin
          if (eng_rdy[ENG_KSA]) begin
            state  <= S_PRGA_EN;
            eng_en <= en_bit(ENG_PRGA);
          end else if (phase_timeout) begin
            state     <= S_ERR;
            busy      <= 1'b0;
            err       <= 1'b1;
            eng_rst_n <= 1'b0;
          end
        end
        S_PRGA_EN: begin
          state     <= S_PRGA_WAIT;
          phase_cnt <= '0;
        end
        S_PRGA_WAIT: begin
          if (eng_rdy[ENG_PRGA]) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (phase_timeout) begin
            state     <= S_ERR;
            busy      <= 1'b0;
            err       <= 1'b1;
            eng_rst_n <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has one cycle of read latency, so valid trails the grant by one cycle
  always_ff @(posedge clk) begin
    if (rst) host_valid <= 1'b0;
    else     host_valid <= host_gnt;
  end

  assign host_rddata = mem_rddata;

  s_mem_mux u_mem_mux (
    .owner      (owner_of(state)),
    .eng_addr   (eng_addr),
    .eng_wrdata (eng_wrdata),
    .eng_wren   (eng_wren),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_block (start),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_wren   (mem_wren),
    .host_gnt   (host_gnt)
  );

endmodule

// File: doc/arc4_sched.md
ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4095, max cycles allowed per engine phase before abort.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to run INIT -> KSA -> PRGA.
REQ-005 key  in  24  cipher key; sampled on accepted start.
REQ-006 key_out  out  24  latched key, held stable to engines for the whole run.
REQ-007 busy / done / err  out  1 each  run in progress / last run completed / last run timed out.
REQ-008 eng_rst_n  out  1  registered active-low reset to the three engines.
REQ-009 eng_en  out  3  enable pulse per engine; bit0 INIT, bit1 KSA, bit2 PRGA.
REQ-010 eng_rdy  in  3  engine ready levels, same bit order.
REQ-011 eng_addr / eng_wrdata  in  24 each  packed 3x8 engine memory requests, engine k in bits [8k+7:8k].
REQ-012 eng_wren  in  3  engine write enables.
REQ-013 mem_addr / mem_wrdata  out  8 each;  mem_wren  out  1  single shared 256x8 S-memory port.
REQ-014 mem_rddata  in  8  synchronous RAM read data, 1-cycle latency.
REQ-015 host_req  in  1;  host_addr  in  8  host read request for S-memory inspection.
REQ-016 host_gnt  out  1;  host_valid  out  1;  host_rddata  out  8  host grant / data valid / data.

Function
REQ-017 States: IDLE, ENG_RST, INIT_EN, INIT_WAIT, KSA_EN, KSA_WAIT, PRGA_EN, PRGA_WAIT, DONE, ERR.
REQ-018 IDLE/DONE/ERR + start=1 -> ENG_RST; key latched into key_out; done, err cleared; busy=1 next cycle.
REQ-019 ENG_RST: eng_rst_n=0 for exactly 2 cycles, then -> INIT_EN.
REQ-020 X_EN: eng_en bit for X high exactly 1 cycle, -> X_WAIT; phase counter cleared.
REQ-021 X_WAIT: eng_rdy bit for X high -> next X_EN (INIT->KSA->PRGA) or DONE after PRGA; rdy already high on X_EN cycle is ignored.
REQ-022 Phase counter (12 bits, saturating) increments each X_WAIT cycle; reaching TIMEOUT_CYCLES without rdy -> ERR.
REQ-023 DONE: done=1, busy=0; ERR: err=1, busy=0, eng_rst_n=0 held; both held until next start or rst.
REQ-024 start while busy=1 is ignored; no queuing.
REQ-025 Memory grant: engine X owns the port in X_EN and X_WAIT; mem_* = that engine's eng_addr/eng_wrdata/eng_wren slice, combinationally.
REQ-026 Non-granted engines' requests are discarded; mem_wren=0 in every state with no engine owner.
REQ-027 Host granted only in IDLE/DONE/ERR: host_gnt = host_req in those states; mem_addr = host_addr, mem_wren = 0.
REQ-028 host_valid asserts exactly 1 cycle after each granted host_req cycle; host_rddata = mem_rddata.
REQ-029 start and host_req in the same idle cycle: start wins; host_gnt=0, no host_valid follows.
REQ-030 eng_en, eng_rst_n, busy, done, err, host_valid registered; mem_* and host_gnt combinational.

Reset
REQ-031 rst=1 -> IDLE next edge; busy=0, done=0, err=0, eng_en=0, eng_rst_n=0, host_valid=0, key_out=0, counter=0.
REQ-032 eng_rst_n released (=1) the first cycle after rst deasserts in IDLE.
REQ-033 rst mid-run aborts immediately; no partial done/err reported.

Structure
REQ-034 Package arc4_pkg: state enum, engine index constants (ENG_INIT=0, ENG_KSA=1, ENG_PRGA=2), phase counter width.
REQ-035 Sub-module s_mem_mux: owner select + packed engine buses + host lines -> mem_* outputs; purely combinational.

Verification
REQ-036 start, key=24'h00033C, engine models rdy after 300/2100/500 cycles -> eng_en pulses in order INIT, KSA, PRGA; done=1 ~2905 cycles after start.
REQ-037 KSA model writes addr 8'h10 data 8'hAA while INIT model drives wren=1 -> only KSA write reaches mem during KSA_WAIT.
REQ-038 KSA model never asserts rdy -> err=1 after 4095 WAIT cycles, eng_rst_n=0, busy=0, done=0.
REQ-039 DONE then host_req, host_addr=8'h05 -> host_gnt same cycle, host_valid next cycle with mem content at 8'h05; host_req while busy -> host_gnt=0.
REQ-040 rst pulse during KSA_WAIT -> IDLE, eng_en=0, done=0; subsequent start completes normally.
REQ-041 start and host_req same idle cycle -> run begins, no host_valid; second start while busy ignored.
